pooling_output_serializer: RTL and testbench

- Downstream neighbour of the pooling array. Consumes one LANES-wide word of pooled results per transfer and emits the lanes one at a time as a single DATA_WIDTH stream with valid/ready handshake.
- Tags the final element of each pooled frame with out_last so the next layer's loader can frame its input.
- A 2-entry ping-pong buffer lets one word be accepted while the previous one drains. This sustains 1 element/cycle at the output.

---
 rtl/pooling_output_serializer.sv | 134 +++++++++++++
 tb/tb_pooling_output_serializer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pooling_output_serializer.sv
// Serializes LANES-wide pooled words into a DATA_WIDTH element stream and tags each frame's final element.
// Lane 0 appears one cycle after the word is accepted. A 2-entry ping-pong buffer absorbs out_ready stalls, and in_ready drops only when both entries are full.
module pooling_output_serializer #(
    parameter int DATA_WIDTH  = 32,
    parameter int LANES       = 3,
    parameter int FRAME_WORDS = 4,
    localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int CNT_W      = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [LANE_W-1:0]           out_lane,
    output logic                        out_last
);

    logic [LANES*DATA_WIDTH-1:0] buf_q [2];
    logic [1:0]                  full_q, full_d;
    logic                        wr_ptr_q, wr_ptr_d;
    logic                        rd_ptr_q, rd_ptr_d;
    logic [LANE_W-1:0]           lane_q, lane_d;
    logic [CNT_W-1:0]            word_q, word_d;
    logic                        out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]       out_data_q, out_data_d;
    logic [LANE_W-1:0]           out_lane_q, out_lane_d;
    logic                        out_last_q, out_last_d;

    logic                        accept;
    logic                        load;
    logic                        last_lane;
    logic                        last_word;
    logic [LANES*DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0]       lane_dat;

    assign in_ready  = !(full_q[0] && full_q[1]);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_lane  = out_lane_q;
    assign out_last  = out_last_q;

    always_comb begin
        accept    = in_valid && in_ready && !clr;
        load      = (!out_valid_q || out_ready) && full_q[rd_ptr_q];
        last_lane = (lane_q == LANE_W'(LANES - 1));
        last_word = (word_q == CNT_W'(FRAME_WORDS - 1));
        rd_word   = buf_q[rd_ptr_q];
        // Lane 0 sits in the most-significant slice of the word.
        lane_dat  = rd_word[(LANES - 1 - int'(lane_q)) * DATA_WIDTH +: DATA_WIDTH];

        full_d      = full_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        lane_d      = lane_q;
        word_d      = word_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_lane_d  = out_lane_q;
        out_last_d  = out_last_q;

        if (accept) begin
            full_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = ~wr_ptr_q;
        end

        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = lane_dat;
            out_lane_d  = lane_q;
            out_last_d  = last_lane && last_word;
            if (last_lane) begin
                full_d[rd_ptr_q] = 1'b0;
                rd_ptr_d         = ~rd_ptr_q;
                lane_d           = '0;
                word_d           = last_word ? '0 : word_q + 1'b1;
            end else begin
                lane_d = lane_q + 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (clr) begin
            full_d      = '0;
            wr_ptr_d    = 1'b0;
            rd_ptr_d    = 1'b0;
            lane_d      = '0;
            word_d      = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_lane_d  = '0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q      <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            lane_q      <= '0;
            word_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_lane_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            full_q      <= full_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            lane_q      <= lane_d;
            word_q      <= word_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_lane_q  <= out_lane_d;
            out_last_q  <= out_last_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else if (accept) begin
            buf_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_pooling_output_serializer.sv
// Bench for pooling_output_serializer: element-queue reference model plus directed and random traffic.
module tb_pooling_output_serializer;

    localparam int DW = 32;
    localparam int L  = 3;
    localparam int FW = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [1:0]    lane;
        logic          last;
    } elem_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            clr;
    logic            in_valid;
    logic            in_ready;
    logic [L*DW-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_lane;
    logic            out_last;

    int n_cmp  = 0;
    int n_fail = 0;

    elem_t q[$];
    int    mw = 0;

    pooling_output_serializer #(
        .DATA_WIDTH (DW),
        .LANES      (L),
        .FRAME_WORDS(FW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_lane (out_lane),
        .out_last (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [L*DW-1:0] mkword(input logic [DW-1:0] base);
        logic [L*DW-1:0] w;
        for (int k = 0; k < L; k++) w[(L-1-k)*DW +: DW] = base + DW'(k);
        return w;
    endfunction

    // Reference model: every accepted word expands into L queued elements in lane order.
    // An element is a frame's last when it is lane L-1 of word FW-1 since reset/clr.
    always @(negedge clk) begin
        int    pend;
        elem_t e;
        if (rst) begin
            q.delete();
            mw = 0;
        end else begin
            pend = q.size() - (out_valid ? 1 : 0);
            chk("in_ready_vs_model", longint'(in_ready), longint'(((pend + L - 1) / L) < 2));
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 1, 0);
                end else begin
                    chk("out_data", longint'(out_data), longint'(q[0].d));
                    chk("out_lane", longint'(out_lane), longint'(q[0].lane));
                    chk("out_last", longint'(out_last), longint'(q[0].last));
                end
            end
            if (clr) begin
                q.delete();
                mw = 0;
            end else begin
                if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
                if (in_valid && in_ready) begin
                    for (int k = 0; k < L; k++) begin
                        e.d    = in_data[(L-1-k)*DW +: DW];
                        e.lane = 2'(k);
                        e.last = (k == L-1) && (mw == FW-1);
                        q.push_back(e);
                    end
                    mw = (mw + 1) % FW;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [L*DW-1:0] d);
        logic rb;
        int   cyc;
        in_valid = 1'b1;
        in_data  = d;
        cyc      = 0;
        do begin
            rb = in_ready;
            tick();
            cyc++;
        end while (!rb && cyc < 50);
        chk("send_word_timeout", longint'(rb), 1);
        in_valid = 1'b0;
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic frame_b2b(input logic [DW-1:0] base);
        int   w, cyc, idx, first, lastv, nv, nlast, lastpos;
        logic rb;
        w = 0; cyc = 0; idx = 0; first = -1; lastv = -1; nv = 0; nlast = 0; lastpos = -1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = mkword(base);
        while ((w < FW || out_valid) && cyc < 100) begin
            rb = in_ready;
            tick();
            cyc++;
            if (rb && in_valid) begin
                w++;
                if (w < FW) in_data = mkword(base + DW'(w * 16));
                else in_valid = 1'b0;
            end
            if (out_valid) begin
                if (first < 0) first = idx;
                lastv = idx;
                nv++;
                if (out_last) begin
                    nlast++;
                    lastpos = nv;
                end
            end
            idx++;
        end
        chk("b2b_timeout", longint'(cyc < 100), 1);
        chk("b2b_words", w, FW);
        chk("b2b_count", nv, FW*L);
        chk("b2b_no_bubble_span", lastv - first + 1, FW*L);
        chk("b2b_nlast", nlast, 1);
        chk("b2b_lastpos", lastpos, FW*L);
    endtask

    initial begin
        int   cyc, acc, nl, tail, wcnt;
        logic rb, hs, lf;

        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_data", longint'(out_data), 0);
        chk("rst_out_lane", longint'(out_lane), 0);
        chk("rst_out_last", longint'(out_last), 0);
        chk("rst_in_ready", longint'(in_ready), 1);

        // Single word: elements appear one cycle after the accepting edge.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = {32'h11, 32'h22, 32'h33};
        tick();
        in_valid = 1'b0;
        chk("sw_valid_at_accept", longint'(out_valid), 0);
        tick();
        chk("sw_e0_valid", longint'(out_valid), 1);
        chk("sw_e0_data", longint'(out_data), 32'h11);
        chk("sw_e0_lane", longint'(out_lane), 0);
        chk("sw_e0_last", longint'(out_last), 0);
        tick();
        chk("sw_e1_data", longint'(out_data), 32'h22);
        chk("sw_e1_lane", longint'(out_lane), 1);
        tick();
        chk("sw_e2_data", longint'(out_data), 32'h33);
        chk("sw_e2_lane", longint'(out_lane), 2);
        chk("sw_e2_last", longint'(out_last), 0);
        tick();
        chk("sw_drained", longint'(out_valid), 0);
        clr_pulse();

        frame_b2b(32'h1000);
        frame_b2b(32'h2000);

        // Backpressure: stall once lane 1 of word 0 is shown.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        wcnt      = 0;
        in_data   = mkword(32'h700);
        cyc       = 0;
        while (!(out_valid && out_lane == 2'd1 && out_data == 32'h701) && cyc < 50) begin
            rb = in_ready;
            tick();
            cyc++;
            if (rb) begin
                wcnt++;
                in_data = mkword(32'h700 + DW'(wcnt * 16));
            end
        end
        chk("bp_reach_lane1", longint'(cyc < 50), 1);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rb = in_ready;
            tick();
            if (rb) begin
                wcnt++;
                in_data = mkword(32'h700 + DW'(wcnt * 16));
            end
            chk("bp_hold_data", longint'(out_data), 32'h701);
            chk("bp_hold_lane", longint'(out_lane), 1);
        end
        chk("bp_in_ready_low", longint'(in_ready), 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while ((out_valid || !in_ready) && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("bp_drain", longint'(cyc < 50), 1);

        // clr while the second word is half drained, with a discarded in_valid.
        send_word(mkword(32'h100));
        send_word(mkword(32'h200));
        cyc = 0;
        while (!(out_valid && out_data == 32'h201) && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("clr_reach", longint'(cyc < 50), 1);
        clr = 1'b1;
        in_valid = 1'b1;
        in_data = mkword(32'h300);
        tick();
        clr = 1'b0;
        in_valid = 1'b0;
        chk("clr_out_valid", longint'(out_valid), 0);
        chk("clr_in_ready", longint'(in_ready), 1);
        frame_b2b(32'h400);

        // Asynchronous reset between edges.
        send_word(mkword(32'h500));
        tick();
        chk("arst_pre_valid", longint'(out_valid), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", longint'(out_valid), 0);
        chk("arst_out_data", longint'(out_data), 0);
        chk("arst_out_lane", longint'(out_lane), 0);
        chk("arst_out_last", longint'(out_last), 0);
        chk("arst_in_ready", longint'(in_ready), 1);
        tick();
        rst = 1'b0;
        frame_b2b(32'h600);

        // Random traffic: 1000 words with random valid/ready.
        acc = 0; cyc = 0; nl = 0; tail = 0;
        in_valid  = 1'(($urandom) & 1);
        in_data   = {$urandom, $urandom, $urandom};
        out_ready = 1'(($urandom) & 1);
        while ((acc < 1000 || tail < 8) && cyc < 30000) begin
            rb = in_ready;
            hs = out_valid && out_ready;
            lf = out_last;
            tick();
            cyc++;
            if (hs && lf) nl++;
            if (in_valid && rb) begin
                acc++;
                in_data = {$urandom, $urandom, $urandom};
            end
            in_valid  = (acc < 1000) ? 1'(($urandom) & 1) : 1'b0;
            out_ready = 1'(($urandom) & 1);
            if (acc >= 1000 && !out_valid && in_ready) tail++;
            else tail = 0;
        end
        chk("rnd_timeout", longint'(cyc < 30000), 1);
        chk("rnd_words", acc, 1000);
        chk("rnd_lasts", nl, 1000 / FW);
        tick();
        chk("end_queue_empty", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
